// File: rtl/mole_round_scheduler_if.sv
// Handshake bundle between the round scheduler, the LFSR/box mapper,
// the player hit detector and the VGA box renderer.
interface mole_round_scheduler_if #(
    parameter int unsigned SCORE_W = 8
);
    logic               start;
    logic [2:0]         lfsr_box;
    logic               lfsr_step;
    logic               hit_valid;
    logic [2:0]         hit_box;
    logic [2:0]         box;
    logic [SCORE_W-1:0] score;
    logic [1:0]         misses;
    logic               round_done;
    logic               game_over;

    // Environment side: drives game control, LFSR code and hits.
    modport master (
        output start, lfsr_box, hit_valid, hit_box,
        input  lfsr_step, box, score, misses, round_done, game_over
    );

    // Scheduler side.
    modport slave (
        input  start, lfsr_box, hit_valid, hit_box,
        output lfsr_step, box, score, misses, round_done, game_over
    );
endinterface

// File: rtl/mole_round_scheduler.sv
// Game-round sequencer: draws a box from the LFSR mapper (rejecting
// repeats and bad codes a bounded number of times), lights it for a
// fixed window, scores matching hits, counts timeouts and ends the game
// after MAX_MISSES. Every output comes straight from a flop.
module mole_round_scheduler #(
    parameter int unsigned SHOW_CYCLES = 50000000,
    parameter int unsigned GAP_CYCLES  = 12500000,
    parameter int unsigned MAX_MISSES  = 3,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned SCORE_W     = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_signal,
    mole_round_scheduler_if.slave bus
);

    localparam int unsigned T_MAX   = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned TIMER_W = (T_MAX < 2) ? 1 : $clog2(T_MAX);
    localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_SETTLE,
        S_SHOW,
        S_GAP,
        S_OVER
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         box_q, box_d;
    logic [2:0]         last_box_q, last_box_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         misses_q, misses_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lfsr_step_q, lfsr_step_d;
    logic               round_done_q, round_done_d;
    logic               game_over_q, game_over_d;

    logic               code_ok;
    logic               reject;
    logic               hit_match;

    assign code_ok   = (bus.lfsr_box >= 3'd2) && (bus.lfsr_box <= 3'd5);
    assign reject    = (!code_ok || (bus.lfsr_box == last_box_q)) &&
                       (retry_q < RETRY_W'(MAX_RETRY));
    assign hit_match = bus.hit_valid && (bus.hit_box == box_q);

    // Next-state and next-output computation for the round FSM.
    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves
        // it unassigned; that is what keeps this block free of latches.
        state_d      = state_q;
        box_d        = box_q;
        last_box_d   = last_box_q;
        score_d      = score_q;
        misses_d     = misses_q;
        timer_d      = timer_q;
        retry_d      = retry_q;
        round_done_d = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    state_d    = S_PICK;
                    score_d    = '0;
                    misses_d   = '0;
                    last_box_d = '0;
                    retry_d    = '0;
                end
            end

            S_PICK: begin
                state_d = S_SETTLE;
            end

            S_SETTLE: begin
                if (reject) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = S_PICK;
                end else begin
                    // Once retries run out a bad code still needs a box.
                    box_d      = code_ok ? bus.lfsr_box : 3'd2;
                    last_box_d = code_ok ? bus.lfsr_box : 3'd2;
                    retry_d    = '0;
                    timer_d    = TIMER_W'(SHOW_CYCLES - 1);
                    state_d    = S_SHOW;
                end
            end

            S_SHOW: begin
                if (hit_match) begin
                    // A hit on the final window cycle beats the timeout.
                    if (score_q != '1) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                    round_done_d = 1'b1;
                    box_d        = '0;
                    timer_d      = TIMER_W'(GAP_CYCLES - 1);
                    state_d      = S_GAP;
                end else if (timer_q == '0) begin
                    misses_d     = misses_q + 2'd1;
                    round_done_d = 1'b1;
                    box_d        = '0;
                    if ((misses_q + 2'd1) == 2'(MAX_MISSES)) begin
                        state_d = S_OVER;
                    end else begin
                        timer_d = TIMER_W'(GAP_CYCLES - 1);
                        state_d = S_GAP;
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            S_GAP: begin
                if (timer_q == '0) begin
                    state_d = S_PICK;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered strobes follow the state being entered.
        lfsr_step_d = (state_d == S_PICK);
        game_over_d = (state_d == S_OVER);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples the pre-edge values computed above.
        if (reset_signal) begin
            state_q      <= S_IDLE;
            box_q        <= '0;
            last_box_q   <= '0;
            score_q      <= '0;
            misses_q     <= '0;
            timer_q      <= '0;
            retry_q      <= '0;
            lfsr_step_q  <= 1'b0;
            round_done_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            box_q        <= box_d;
            last_box_q   <= last_box_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            lfsr_step_q  <= lfsr_step_d;
            round_done_q <= round_done_d;
            game_over_q  <= game_over_d;
        end
    end

    assign bus.box        = box_q;
    assign bus.score      = score_q;
    assign bus.misses     = misses_q;
    assign bus.lfsr_step  = lfsr_step_q;
    assign bus.round_done = round_done_q;
    assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Directed bench for the round scheduler with short sim windows
// (SHOW_CYCLES=8, GAP_CYCLES=4). Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_mole_round_scheduler;

    logic CLOCK_50;
    logic reset_signal;
    int   total = 0;
    int   bad   = 0;

    mole_round_scheduler_if #(.SCORE_W(8)) bus ();

    mole_round_scheduler #(
        .SHOW_CYCLES (8),
        .GAP_CYCLES  (4),
        .MAX_MISSES  (3),
        .MAX_RETRY   (3),
        .SCORE_W     (8)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset_signal (reset_signal),
        .bus          (bus.slave)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic hit(input logic [2:0] b);
        bus.hit_valid = 1'b1;
        bus.hit_box   = b;
        step();
        bus.hit_valid = 1'b0;
        bus.hit_box   = 3'd0;
    endtask

    // From the first GAP cycle: three more GAP cycles, then PICK.
    task automatic to_pick();
        repeat (4) step();
        chk("gap_to_pick", 32'(bus.lfsr_step), 1);
    endtask

    // From PICK: show box b and hit it on the first SHOW cycle.
    task automatic hit_round(input logic [2:0] b);
        bus.lfsr_box = b;
        step();
        step();
        chk("hr_box", 32'(bus.box), 32'(b));
        hit(b);
        to_pick();
    endtask

    // From PICK: show box b and let the full 8-cycle window expire.
    task automatic timeout_round(input logic [2:0] b);
        bus.lfsr_box = b;
        step();
        step();
        chk("to_box", 32'(bus.box), 32'(b));
        repeat (7) step();
        chk("to_last_cycle_box", 32'(bus.box), 32'(b));
        step();
        chk("to_round_done", 32'(bus.round_done), 1);
    endtask

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_signal  = 1'b1;
        bus.start     = 1'b0;
        bus.lfsr_box  = 3'd0;
        bus.hit_valid = 1'b0;
        bus.hit_box   = 3'd0;
        step();
        step();
        chk("rst_box",        32'(bus.box), 0);
        chk("rst_score",      32'(bus.score), 0);
        chk("rst_misses",     32'(bus.misses), 0);
        chk("rst_game_over",  32'(bus.game_over), 0);
        chk("rst_lfsr_step",  32'(bus.lfsr_step), 0);
        chk("rst_round_done", 32'(bus.round_done), 0);
        reset_signal = 1'b0;
        step();
        chk("idle_lfsr_step", 32'(bus.lfsr_step), 0);

        // Start latency, full window, timeout, exact gap.
        bus.lfsr_box = 3'd4;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        chk("t2_pick_step", 32'(bus.lfsr_step), 1);
        chk("t2_pick_box",  32'(bus.box), 0);
        step();
        chk("t2_settle_step", 32'(bus.lfsr_step), 0);
        chk("t2_settle_box",  32'(bus.box), 0);
        step();
        chk("t2_box", 32'(bus.box), 4);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t2_hold_box", 32'(bus.box), 4);
            chk("t2_hold_rd",  32'(bus.round_done), 0);
        end
        step();
        chk("t2_miss_misses", 32'(bus.misses), 1);
        chk("t2_miss_rd",     32'(bus.round_done), 1);
        chk("t2_miss_box",    32'(bus.box), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_gap_box",  32'(bus.box), 0);
            chk("t2_gap_rd",   32'(bus.round_done), 0);
            chk("t2_gap_step", 32'(bus.lfsr_step), 0);
        end
        step();
        chk("t2_gap_end_step", 32'(bus.lfsr_step), 1);

        // Matching hit on the 3rd SHOW cycle.
        bus.lfsr_box = 3'd5;
        step();
        step();
        chk("t3_box", 32'(bus.box), 5);
        step();
        step();
        hit(3'd5);
        chk("t3_score",  32'(bus.score), 1);
        chk("t3_rd",     32'(bus.round_done), 1);
        chk("t3_box0",   32'(bus.box), 0);
        chk("t3_misses", 32'(bus.misses), 1);
        to_pick();

        // Wrong-box hit is ignored and the timeout still happens.
        bus.lfsr_box = 3'd3;
        step();
        step();
        chk("t3w_box", 32'(bus.box), 3);
        step();
        step();
        hit(3'd2);
        chk("t3w_score", 32'(bus.score), 1);
        chk("t3w_box3",  32'(bus.box), 3);
        chk("t3w_rd",    32'(bus.round_done), 0);
        repeat (4) step();
        step();
        chk("t3w_misses", 32'(bus.misses), 2);
        chk("t3w_rd1",    32'(bus.round_done), 1);
        chk("t3w_box0",   32'(bus.box), 0);
        to_pick();
        hit_round(3'd5);
        chk("t1_pre_score", 32'(bus.score), 2);

        // Reset mid-SHOW overrides start and hit in the same cycle.
        bus.lfsr_box = 3'd3;
        step();
        step();
        chk("t1_pre_box", 32'(bus.box), 3);
        step();
        reset_signal  = 1'b1;
        bus.start     = 1'b1;
        bus.hit_valid = 1'b1;
        bus.hit_box   = 3'd3;
        step();
        chk("t1_box",       32'(bus.box), 0);
        chk("t1_score",     32'(bus.score), 0);
        chk("t1_misses",    32'(bus.misses), 0);
        chk("t1_game_over", 32'(bus.game_over), 0);
        chk("t1_step",      32'(bus.lfsr_step), 0);
        reset_signal  = 1'b0;
        bus.start     = 1'b0;
        bus.hit_valid = 1'b0;
        bus.hit_box   = 3'd0;
        step();
        chk("t1_idle_step", 32'(bus.lfsr_step), 0);
        chk("t1_idle_box",  32'(bus.box), 0);

        // Repeats of last_box force three re-draws before acceptance.
        bus.lfsr_box = 3'd4;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        chk("t4_first_box", 32'(bus.box), 4);
        hit(3'd4);
        chk("t4_score1", 32'(bus.score), 1);
        to_pick();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_settle_step", 32'(bus.lfsr_step), 0);
            chk("t4_settle_box",  32'(bus.box), 0);
            step();
            chk("t4_restep", 32'(bus.lfsr_step), 1);
        end
        step();
        chk("t4_final_settle", 32'(bus.lfsr_step), 0);
        step();
        chk("t4_repeat_accept", 32'(bus.box), 4);
        hit(3'd4);
        chk("t4_score2", 32'(bus.score), 2);
        to_pick();

        // Out-of-range code after exhausted retries becomes box 2.
        bus.lfsr_box = 3'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4z_settle_step", 32'(bus.lfsr_step), 0);
            step();
            chk("t4z_restep", 32'(bus.lfsr_step), 1);
        end
        step();
        step();
        chk("t4z_sub_box", 32'(bus.box), 2);

        // Hit on the timer==0 cycle wins over the timeout.
        repeat (7) step();
        chk("t6_last_box", 32'(bus.box), 2);
        hit(3'd2);
        chk("t6_score",  32'(bus.score), 3);
        chk("t6_misses", 32'(bus.misses), 0);
        chk("t6_rd",     32'(bus.round_done), 1);
        chk("t6_box",    32'(bus.box), 0);
        to_pick();

        // Three consecutive timeouts end the game.
        timeout_round(3'd3);
        chk("t5_misses1", 32'(bus.misses), 1);
        chk("t5_go1",     32'(bus.game_over), 0);
        to_pick();
        timeout_round(3'd5);
        chk("t5_misses2", 32'(bus.misses), 2);
        to_pick();
        timeout_round(3'd3);
        chk("t5_misses3", 32'(bus.misses), 3);
        chk("t5_go",      32'(bus.game_over), 1);
        chk("t5_box",     32'(bus.box), 0);
        step();
        chk("t5_rd_pulse", 32'(bus.round_done), 0);
        chk("t5_go_held",  32'(bus.game_over), 1);
        chk("t5_no_step",  32'(bus.lfsr_step), 0);
        hit(3'd3);
        chk("t5_over_score",  32'(bus.score), 3);
        chk("t5_over_misses", 32'(bus.misses), 3);
        chk("t5_over_rd",     32'(bus.round_done), 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("t5_restart_go",     32'(bus.game_over), 0);
        chk("t5_restart_score",  32'(bus.score), 0);
        chk("t5_restart_misses", 32'(bus.misses), 0);
        chk("t5_restart_step",   32'(bus.lfsr_step), 1);

        // Score saturates at 255.
        for (int i = 0; i < 256; i++) begin
            hit_round(3'(2 + (i % 2)));
            if (i == 254) chk("t6_score_255", 32'(bus.score), 255);
        end
        chk("t6_score_sat", 32'(bus.score), 255);
        chk("t6_sat_misses", 32'(bus.misses), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
